// File: rtl/branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// EX-stage branch/jump resolution controller. It compares the forwarded
// operands (signed or unsigned, chosen by funct3) and decides taken/not-taken
// under a static not-taken policy. A taken branch or jump produces a one-cycle
// registered PC redirect and a FLUSH_CYCLES-long squash of IF/ID and ID/EX.
// While the operands wait on a load result, the front end is stalled. The
// block also counts resolved and taken conditional branches.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   br_valid        EX holds a conditional branch, JAL or JALR
//   br_funct3       branch funct3 (ignored for jumps)
//   is_jal/is_jalr  EX instruction is a jump
//   opnd_ready      forwarded operands valid (0 = load-use pending)
//   rs1_val/rs2_val forwarded operands
//   pc_ex, imm      PC of EX instruction, sign-extended immediate
//   stall_req       hold IF/ID/EX (combinational)
//   redirect_valid  one-cycle redirect strobe (registered)
//   redirect_pc     redirect target (registered)
//   flush_ifid/idex squash strobes (registered)
//   busy            controller is not idle
//   branch_cnt      resolved conditional branches
//   taken_cnt       taken conditional branches
// ----------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [2:0]       br_funct3,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             opnd_ready,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  pc_ex,
    input  logic [XLEN-1:0]  imm,
    output logic             stall_req,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Counter only needs to hold FLUSH_CYCLES-1 down to 0.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_OPND,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic              is_jump;
    logic              use_unsigned;
    logic              op_eq;
    logic              op_gt;
    logic              op_lt;
    logic              cond_taken;
    logic              taken;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   target;

    // ---------------- comparison and target ----------------
    assign is_jump      = is_jal | is_jalr;
    // funct3 11x (BLTU/BGEU) compares unsigned; everything else signed.
    assign use_unsigned = br_funct3[2] & br_funct3[1];
    assign op_eq        = (rs1_val == rs2_val);
    assign op_gt        = use_unsigned ? (rs1_val > rs2_val)
                                       : ($signed(rs1_val) > $signed(rs2_val));
    assign op_lt        = ~op_eq & ~op_gt;

    always_comb begin
        cond_taken = 1'b0;
        case (br_funct3)
            3'b000:         cond_taken = op_eq;
            3'b001:         cond_taken = ~op_eq;
            3'b100, 3'b110: cond_taken = op_lt;
            3'b101, 3'b111: cond_taken = ~op_lt;
            default:        cond_taken = 1'b0;  // 010/011: never taken
        endcase
    end

    assign taken    = is_jump | cond_taken;
    assign jalr_sum = rs1_val + imm;
    assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_ex + imm);

    // Wrong-path instructions seen during FLUSH must not stall the front end.
    assign stall_req = br_valid & ~opnd_ready & (state_q != S_FLUSH);

    // ---------------- next state ----------------
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        branch_cnt_d     = branch_cnt_q;
        taken_cnt_d      = taken_cnt_q;

        case (state_q)
            S_IDLE, S_WAIT_OPND: begin
                if (!br_valid) begin
                    state_d = S_IDLE;
                end else if (!opnd_ready) begin
                    state_d = S_WAIT_OPND;
                end else begin
                    state_d = S_IDLE;
                    if (!is_jump) begin
                        branch_cnt_d = branch_cnt_q + CNT_W'(1);
                    end
                    if (taken) begin
                        if (!is_jump) begin
                            taken_cnt_d = taken_cnt_q + CNT_W'(1);
                        end
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target;
                        flush_d          = 1'b1;
                        flush_cnt_d      = FC_W'(FLUSH_CYCLES - 1);
                        state_d          = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // flush_cnt_q counts the flush cycles still to come after this one.
                if (flush_cnt_q == '0) begin
                    flush_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            branch_cnt_q     <= branch_cnt_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_ifid     = flush_q;
    assign flush_idex     = flush_q;
    assign busy           = (state_q != S_IDLE);
    assign branch_cnt     = branch_cnt_q;
    assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for branch_resolve_ctrl. Two instances share the same stimulus:
// one with the default FLUSH_CYCLES=2 and one with FLUSH_CYCLES=3. The
// reference model works on absolute cycle numbers: it remembers the cycle in
// which each instance last resolved a taken branch, and derives the flush
// window, redirect strobe and busy/stall behaviour from that.
// ----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             br_valid;
    logic [2:0]       br_funct3;
    logic             is_jal;
    logic             is_jalr;
    logic             opnd_ready;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  pc_ex;
    logic [XLEN-1:0]  imm;

    logic             stall_a, rv_a, fi_a, fe_a, busy_a;
    logic [XLEN-1:0]  rpc_a;
    logic [CNT_W-1:0] bc_a, tc_a;
    logic             stall_b, rv_b, fi_b, fe_b, busy_b;
    logic [XLEN-1:0]  rpc_b;
    logic [CNT_W-1:0] bc_b, tc_b;

    branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_funct3(br_funct3),
        .is_jal(is_jal), .is_jalr(is_jalr), .opnd_ready(opnd_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .pc_ex(pc_ex), .imm(imm),
        .stall_req(stall_a), .redirect_valid(rv_a), .redirect_pc(rpc_a),
        .flush_ifid(fi_a), .flush_idex(fe_a), .busy(busy_a),
        .branch_cnt(bc_a), .taken_cnt(tc_a)
    );

    branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(3), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_funct3(br_funct3),
        .is_jal(is_jal), .is_jalr(is_jalr), .opnd_ready(opnd_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .pc_ex(pc_ex), .imm(imm),
        .stall_req(stall_b), .redirect_valid(rv_b), .redirect_pc(rpc_b),
        .flush_ifid(fi_b), .flush_idex(fe_b), .busy(busy_b),
        .branch_cnt(bc_b), .taken_cnt(tc_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int               fcs[2] = '{2, 3};
    int               taken_at[2];
    bit               waiting[2];
    logic [XLEN-1:0]  m_rpc[2];
    logic [CNT_W-1:0] m_bc[2];
    logic [CNT_W-1:0] m_tc[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            taken_at[k] = -100;
            waiting[k]  = 1'b0;
            m_rpc[k]    = '0;
            m_bc[k]     = '0;
            m_tc[k]     = '0;
        end
    endtask

    // Branch decision straight from the instruction semantics.
    function automatic bit ref_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b, input bit jump);
        bit lt_s;
        bit lt_u;
        if (jump) return 1'b1;
        lt_s = ($signed(a) < $signed(b));
        lt_u = (a < b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return lt_s;
            3'b101:  return !lt_s;
            3'b110:  return lt_u;
            3'b111:  return !lt_u;
            default: return 1'b0;
        endcase
    endfunction

    // Checks all outputs for the current cycle, advances the model, then
    // moves to the next negedge.
    task automatic step();
        bit               inf[2];
        bit               jump;
        bit               tk;
        logic [XLEN-1:0]  tgt;
        #1;
        for (int k = 0; k < 2; k++) begin
            inf[k] = (cyc >= taken_at[k] + 1) && (cyc <= taken_at[k] + fcs[k]);
            chk(k == 0 ? "A.redirect_valid" : "B.redirect_valid",
                k == 0 ? 64'(rv_a) : 64'(rv_b), 64'(cyc == taken_at[k] + 1));
            chk(k == 0 ? "A.redirect_pc" : "B.redirect_pc",
                k == 0 ? 64'(rpc_a) : 64'(rpc_b), 64'(m_rpc[k]));
            chk(k == 0 ? "A.flush_ifid" : "B.flush_ifid",
                k == 0 ? 64'(fi_a) : 64'(fi_b), 64'(inf[k]));
            chk(k == 0 ? "A.flush_idex" : "B.flush_idex",
                k == 0 ? 64'(fe_a) : 64'(fe_b), 64'(inf[k]));
            chk(k == 0 ? "A.busy" : "B.busy",
                k == 0 ? 64'(busy_a) : 64'(busy_b), 64'(inf[k] || waiting[k]));
            chk(k == 0 ? "A.stall_req" : "B.stall_req",
                k == 0 ? 64'(stall_a) : 64'(stall_b),
                64'(!inf[k] && br_valid && !opnd_ready));
            chk(k == 0 ? "A.branch_cnt" : "B.branch_cnt",
                k == 0 ? 64'(bc_a) : 64'(bc_b), 64'(m_bc[k]));
            chk(k == 0 ? "A.taken_cnt" : "B.taken_cnt",
                k == 0 ? 64'(tc_a) : 64'(tc_b), 64'(m_tc[k]));
        end
        $display("cyc=%0d rst=%b br=%b f3=%0d jal=%b jalr=%b rdy=%b rs1=%h rs2=%h pc=%h imm=%h | A rv=%b pc=%h fl=%b st=%b bc=%0d tc=%0d | B rv=%b pc=%h fl=%b st=%b bc=%0d tc=%0d",
                 cyc, rst, br_valid, br_funct3, is_jal, is_jalr, opnd_ready, rs1_val, rs2_val,
                 pc_ex, imm, rv_a, rpc_a, fi_a, stall_a, bc_a, tc_a, rv_b, rpc_b, fi_b, stall_b,
                 bc_b, tc_b);

        jump = is_jal || is_jalr;
        tk   = ref_taken(br_funct3, rs1_val, rs2_val, jump);
        tgt  = is_jalr ? ((rs1_val + imm) & ~XLEN'(1)) : (pc_ex + imm);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!inf[k] && br_valid && opnd_ready) begin
                    if (!jump) m_bc[k] = m_bc[k] + 1;
                    if (tk) begin
                        if (!jump) m_tc[k] = m_tc[k] + 1;
                        taken_at[k] = cyc;
                        m_rpc[k]    = tgt;
                    end
                end
                waiting[k] = !inf[k] && br_valid && !opnd_ready;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input bit bv, input logic [2:0] f3, input bit jal, input bit jalr,
                         input bit rdy, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] im);
        br_valid   = bv;
        br_funct3  = f3;
        is_jal     = jal;
        is_jalr    = jalr;
        opnd_ready = rdy;
        rs1_val    = a;
        rs2_val    = b;
        pc_ex      = pc;
        imm        = im;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 3'b000, 0, 0, 1, '0, '0, '0, '0);
    endtask

    initial begin
        int kind;
        rst = 1'b1;
        br_valid = 0; br_funct3 = '0; is_jal = 0; is_jalr = 0; opnd_ready = 1;
        rs1_val = '0; rs2_val = '0; pc_ex = '0; imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset state
        idle(1);
        chk("reset_busy", 64'(busy_a), 64'(0));
        chk("reset_bc", 64'(bc_a), 64'(0));

        // BEQ taken: redirect to 0x120, flush 2 cycles on A
        drive(1, 3'b000, 0, 0, 1, 32'h5, 32'h5, 32'h100, 32'h20);
        chk("beq_rv", 64'(rv_a), 64'(1));
        chk("beq_rpc", 64'(rpc_a), 64'h120);
        chk("beq_cnt", 64'(bc_a) << 32 | 64'(tc_a), 64'h1_0000_0001);
        idle(4);

        // BLT taken, BLTU not taken (0xFFFFFFFF vs 1)
        drive(1, 3'b100, 0, 0, 1, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
        chk("blt_rv", 64'(rv_a), 64'(1));
        idle(4);
        drive(1, 3'b110, 0, 0, 1, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40);
        chk("bltu_rv", 64'(rv_a), 64'(0));
        chk("bltu_bc", 64'(bc_a), 64'(3));
        chk("bltu_tc", 64'(tc_a), 64'(2));
        idle(1);

        // JALR target with bit0 cleared, JAL with wrap
        drive(1, 3'b000, 0, 1, 1, 32'h1003, 32'h0, 32'h500, 32'h4);
        chk("jalr_rpc", 64'(rpc_a), 64'h1006);
        idle(4);
        drive(1, 3'b000, 1, 0, 1, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
        chk("jal_wrap_rpc", 64'(rpc_a), 64'h10);
        chk("jal_bc", 64'(bc_a), 64'(3));
        idle(4);

        // BNE waiting on operands for 3 cycles
        for (int i = 0; i < 3; i++) drive(1, 3'b001, 0, 0, 0, 32'h1, 32'h2, 32'h600, 32'h8);
        drive(1, 3'b001, 0, 0, 1, 32'h1, 32'h2, 32'h600, 32'h8);
        chk("bne_rv", 64'(rv_a), 64'(1));
        chk("bne_rpc", 64'(rpc_a), 64'h608);
        idle(4);

        // Back-to-back not-taken then taken
        drive(1, 3'b000, 0, 0, 1, 32'h1, 32'h2, 32'h700, 32'h10);
        drive(1, 3'b101, 0, 0, 1, 32'h9, 32'h2, 32'h704, 32'h10);
        idle(4);

        // Branch held valid during flush is wrong-path and ignored
        drive(1, 3'b000, 0, 0, 1, 32'h7, 32'h7, 32'h800, 32'h40);
        drive(1, 3'b000, 0, 0, 1, 32'h7, 32'h7, 32'h900, 32'h40);
        drive(1, 3'b000, 0, 0, 0, 32'h7, 32'h7, 32'h900, 32'h40);
        idle(4);

        // Reset mid-flush
        drive(1, 3'b001, 0, 0, 1, 32'h1, 32'h2, 32'hA00, 32'h4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        chk("rst_flush_busy", 64'(busy_b), 64'(0));
        chk("rst_flush_tc", 64'(tc_b), 64'(0));

        // Reset mid-WAIT_OPND
        drive(1, 3'b000, 0, 0, 0, 32'h1, 32'h1, 32'hB00, 32'h4);
        rst = 1'b1;
        drive(1, 3'b000, 0, 0, 0, 32'h1, 32'h1, 32'hB00, 32'h4);
        rst = 1'b0;
        idle(2);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 7));
            rst  = ($urandom_range(0, 99) == 0);
            rs1_val = (($urandom & 3) == 0) ? XLEN'($urandom & 32'hF) : XLEN'($urandom);
            rs2_val = (($urandom & 3) == 0) ? rs1_val
                     : ((($urandom & 3) == 0) ? XLEN'($urandom & 32'hF) : XLEN'($urandom));
            drive(($urandom & 3) != 0, 3'($urandom), kind == 0, kind == 1,
                  ($urandom & 3) != 0, rs1_val, rs2_val, XLEN'($urandom), XLEN'($urandom));
        end
        rst = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
